// File: rtl/tsm_pkg.sv
// Shared constants for the test status monitor: state encoding and parameter defaults.
package tsm_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } tsm_state_e;

    localparam int TSM_XLEN           = 32;
    localparam int TSM_REG_AW         = 5;
    localparam int TSM_DONE_REG       = 26;
    localparam int TSM_RESULT_REG     = 27;
    localparam int TSM_TESTNUM_REG    = 3;
    localparam int TSM_SETTLE_CYCLES  = 2;
    localparam int TSM_TIMEOUT_CYCLES = 100000;
    localparam int TSM_CNT_W          = 32;

endpackage

// File: rtl/tsm_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low reset plus a clear.
module tsm_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/test_status_monitor.sv
// Watches core register writeback for the test-end handshake and holds a
// pass/fail/timeout verdict, the current test number and a run-cycle count.
module test_status_monitor
    import tsm_pkg::*;
#(
    parameter int XLEN           = TSM_XLEN,
    parameter int REG_AW         = TSM_REG_AW,
    parameter int DONE_REG       = TSM_DONE_REG,
    parameter int RESULT_REG     = TSM_RESULT_REG,
    parameter int TESTNUM_REG    = TSM_TESTNUM_REG,
    parameter int SETTLE_CYCLES  = TSM_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = TSM_TIMEOUT_CYCLES,
    parameter int CNT_W          = TSM_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [XLEN-1:0]   testnum_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [2:0]        state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW:0] TMO_LIM = (TW+1)'(TIMEOUT_CYCLES);

    tsm_state_e      state_q;
    logic [SW-1:0]   settle_q;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] testnum_q, testnum_d;
    logic            done_q, pass_q, fail_q, tmo_q;
    logic [TW-1:0]   tmo_cnt;
    logic            active, wr, done_wr, pass_d, settle_end, tmo_hit;
    logic            go_settle, go_verdict, go_tmo;

    assign active  = (state_q == ST_RUN) || (state_q == ST_SETTLE);
    assign wr      = active && we_i && (waddr_i != '0);
    assign done_wr = wr && (waddr_i == REG_AW'(DONE_REG)) && (wdata_i == XLEN'(1));

    // Next shadow values let a RESULT write in the final settle cycle decide the verdict.
    always_comb begin
        result_d  = result_q;
        testnum_d = testnum_q;
        if (wr && (waddr_i == REG_AW'(RESULT_REG)))  result_d  = wdata_i;
        if (wr && (waddr_i == REG_AW'(TESTNUM_REG))) testnum_d = wdata_i;
    end

    assign pass_d     = (result_d == XLEN'(1));
    assign settle_end = (int'(settle_q) == SETTLE_CYCLES - 1);
    // Fires only on the edge the count reaches the limit; a done on that edge wins.
    assign tmo_hit    = active && (({1'b0, tmo_cnt} + (TW+1)'(1)) == TMO_LIM);

    assign go_settle  = (state_q == ST_RUN) && done_wr && (SETTLE_CYCLES != 0);
    assign go_verdict = ((state_q == ST_RUN) && done_wr && (SETTLE_CYCLES == 0)) ||
                        ((state_q == ST_SETTLE) && settle_end);
    assign go_tmo     = tmo_hit && !go_settle && !go_verdict;

    tsm_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear_i),
        .inc_i (active),
        .cnt_o (cycle_cnt_o)
    );

    tsm_sat_counter #(.W(TW)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear_i),
        .inc_i (active),
        .cnt_o (tmo_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            state_q   <= ST_RUN;
            settle_q  <= '0;
            result_q  <= '0;
            testnum_q <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            result_q  <= result_d;
            testnum_q <= testnum_d;
            if (go_verdict) begin
                state_q <= pass_d ? ST_PASS : ST_FAIL;
                done_q  <= 1'b1;
                pass_q  <= pass_d;
                fail_q  <= !pass_d;
            end else if (go_settle) begin
                state_q  <= ST_SETTLE;
                settle_q <= '0;
            end else if (go_tmo) begin
                state_q <= ST_TIMEOUT;
                done_q  <= 1'b1;
                tmo_q   <= 1'b1;
            end else if (state_q == ST_SETTLE) begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign timeout_o = tmo_q;
    assign testnum_o = testnum_q;
    assign state_o   = state_q;

endmodule
